// File: rtl/vdp_sprite_line_evaluator_pkg.sv
// Shared types for the per-line sprite evaluator: FSM encoding and width helpers.
package vdp_sprite_line_evaluator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_TERM  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Wider of two widths, used to compare Y distance against sprite height.
    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vdp_sprite_line_evaluator_y_compare.sv
// Registered Y-intersection stage: wrap-around line distance, height compare
// and optional vertical flip, tagged with one valid bit and the sprite id.
module vdp_sprite_line_evaluator_y_compare
    import vdp_sprite_line_evaluator_pkg::*;
#(
    parameter int Y_WIDTH      = 9,
    parameter int HEIGHT_WIDTH = 6,
    parameter int ID_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush_i,
    input  logic                    vld_i,
    input  logic [Y_WIDTH-1:0]      render_y_i,
    input  logic [Y_WIDTH-1:0]      sprite_y_i,
    input  logic [HEIGHT_WIDTH-1:0] height_i,
    input  logic                    flip_i,
    input  logic                    wsel_i,
    input  logic [ID_WIDTH-1:0]     id_i,
    output logic                    vld_o,
    output logic                    hit_o,
    output logic [HEIGHT_WIDTH-1:0] intersect_o,
    output logic                    wsel_o,
    output logic [ID_WIDTH-1:0]     id_o
);

    localparam int CW = max_w(Y_WIDTH, HEIGHT_WIDTH);

    logic [Y_WIDTH-1:0]      diff;
    logic [CW-1:0]           diff_x;
    logic [CW-1:0]           height_x;
    logic                    hit_c;
    logic [HEIGHT_WIDTH-1:0] isect_c;

    logic                    vld_p1_q;
    logic                    hit_p1_q;
    logic [HEIGHT_WIDTH-1:0] isect_p1_q;
    logic                    wsel_p1_q;
    logic [ID_WIDTH-1:0]     id_p1_q;

    // Distance wraps modulo 2^Y_WIDTH so sprites straddling the bottom edge hit line 0 onward.
    always_comb begin
        diff     = render_y_i - sprite_y_i;
        diff_x   = CW'(diff);
        height_x = CW'(height_i);
        hit_c    = (diff_x < height_x);
        isect_c  = flip_i ? HEIGHT_WIDTH'(height_x - CW'(1) - diff_x) : HEIGHT_WIDTH'(diff_x);
    end

    // Valid tag is control and is cleared when the scan restarts or overflows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q <= 1'b0;
        end else if (flush_i) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_i;
        end
    end

    // Result payload, qualified by the valid tag.
    always_ff @(posedge clk) begin
        hit_p1_q   <= hit_c;
        isect_p1_q <= isect_c;
        wsel_p1_q  <= wsel_i;
        id_p1_q    <= id_i;
    end

    assign vld_o       = vld_p1_q;
    assign hit_o       = hit_p1_q;
    assign intersect_o = isect_p1_q;
    assign wsel_o      = wsel_p1_q;
    assign id_o        = id_p1_q;

endmodule

// File: rtl/vdp_sprite_line_evaluator.sv
// Per-line sprite evaluator: scans every sprite's Y attributes once per line,
// writes intersecting sprites to the hit list, flags overflow, appends a terminator.
module vdp_sprite_line_evaluator
    import vdp_sprite_line_evaluator_pkg::*;
#(
    parameter int SPRITES_TOTAL  = 256,
    parameter int HIT_LIST_DEPTH = 64,
    parameter int Y_WIDTH        = 9,
    parameter int HEIGHT_WIDTH   = 6,
    parameter int READ_LATENCY   = 2,
    localparam int ID_WIDTH      = $clog2(SPRITES_TOTAL),
    localparam int IDX_WIDTH     = $clog2(HIT_LIST_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [Y_WIDTH-1:0]      render_y,
    output logic [ID_WIDTH-1:0]     sprite_test_id,
    input  logic [Y_WIDTH-1:0]      sprite_y,
    input  logic [HEIGHT_WIDTH-1:0] sprite_height,
    input  logic                    flip_y,
    input  logic                    width_select_in,
    output logic                    hit_list_write_en,
    output logic [IDX_WIDTH-1:0]    hit_list_index,
    output logic [ID_WIDTH-1:0]     hit_sprite_id,
    output logic [HEIGHT_WIDTH-1:0] hit_y_intersect,
    output logic                    hit_width_select,
    output logic                    hit_terminator,
    output logic [IDX_WIDTH-1:0]    hit_count,
    output logic                    busy,
    output logic                    finished,
    output logic                    overflow,
    output logic [ID_WIDTH-1:0]     overflow_sprite_id
);

    localparam logic [IDX_WIDTH-1:0] DEPTH   = IDX_WIDTH'(HIT_LIST_DEPTH);
    localparam logic [IDX_WIDTH-1:0] CNT_ONE = IDX_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0]  LAST_ID = ID_WIDTH'(SPRITES_TOTAL - 1);
    localparam logic [ID_WIDTH-1:0]  ID_ONE  = ID_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic [ID_WIDTH-1:0]     ovf_id_q, ovf_id_d;
    logic [Y_WIDTH-1:0]      ry_q;

    logic [READ_LATENCY-1:0] vld_q;
    logic [ID_WIDTH-1:0]     id_pipe_q [READ_LATENCY];

    logic                    cmp_vld;
    logic                    cmp_hit;
    logic [HEIGHT_WIDTH-1:0] cmp_isect;
    logic                    cmp_ws;
    logic [ID_WIDTH-1:0]     cmp_id;

    logic issue, flush, list_full, hit_wr, ovf_det, term_wr;

    assign issue = (state_q == ST_SCAN) && !start;
    assign flush = start || ovf_det;

    // Line number is captured once per scan so the renderer may move on.
    always_ff @(posedge clk) begin
        if (start) begin
            ry_q <= render_y;
        end
    end

    // Valid bits follow each issued address until its attributes arrive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Sprite id travels alongside the attribute read.
    always_ff @(posedge clk) begin
        id_pipe_q[0] <= id_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            id_pipe_q[i] <= id_pipe_q[i-1];
        end
    end

    vdp_sprite_line_evaluator_y_compare #(
        .Y_WIDTH      (Y_WIDTH),
        .HEIGHT_WIDTH (HEIGHT_WIDTH),
        .ID_WIDTH     (ID_WIDTH)
    ) u_y_compare (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (flush),
        .vld_i       (vld_q[READ_LATENCY-1]),
        .render_y_i  (ry_q),
        .sprite_y_i  (sprite_y),
        .height_i    (sprite_height),
        .flip_i      (flip_y),
        .wsel_i      (width_select_in),
        .id_i        (id_pipe_q[READ_LATENCY-1]),
        .vld_o       (cmp_vld),
        .hit_o       (cmp_hit),
        .intersect_o (cmp_isect),
        .wsel_o      (cmp_ws),
        .id_o        (cmp_id)
    );

    // Next-state, write decisions and counters; a start overrides everything else.
    always_comb begin
        list_full = (cnt_q == DEPTH);
        hit_wr    = cmp_vld && cmp_hit && !list_full && !start;
        ovf_det   = cmp_vld && cmp_hit && list_full && !start;
        term_wr   = (state_q == ST_TERM) && !list_full && !start;

        state_d  = state_q;
        id_d     = id_q;
        cnt_d    = hit_wr ? (cnt_q + CNT_ONE) : cnt_q;
        ovf_d    = ovf_q;
        ovf_id_d = ovf_id_q;

        if (ovf_det) begin
            ovf_d    = 1'b1;
            ovf_id_d = cmp_id;
        end

        case (state_q)
            ST_SCAN: begin
                if (ovf_det) begin
                    state_d = ST_DONE;
                end else if (id_q == LAST_ID) begin
                    state_d = ST_DRAIN;
                end else begin
                    id_d = id_q + ID_ONE;
                end
            end
            ST_DRAIN: begin
                if (ovf_det) begin
                    state_d = ST_DONE;
                end else if (vld_q == '0) begin
                    state_d = ST_TERM;
                end
            end
            ST_TERM:          state_d = ST_DONE;
            ST_IDLE, ST_DONE: state_d = state_q;
            default:          state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d  = ST_SCAN;
            id_d     = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            ovf_id_d = '0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ovf_id_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            ovf_id_q <= ovf_id_d;
        end
    end

    assign sprite_test_id     = id_q;
    assign busy               = (state_q == ST_SCAN) || (state_q == ST_DRAIN) || (state_q == ST_TERM);
    assign finished           = (state_q == ST_DONE);
    assign hit_list_write_en  = hit_wr || term_wr;
    assign hit_list_index     = cnt_q;
    assign hit_sprite_id      = hit_wr ? cmp_id : '0;
    assign hit_y_intersect    = hit_wr ? cmp_isect : '0;
    assign hit_width_select   = hit_wr && cmp_ws;
    assign hit_terminator     = term_wr;
    assign hit_count          = cnt_q;
    assign overflow           = ovf_q || ovf_det;
    assign overflow_sprite_id = ovf_q ? ovf_id_q : (ovf_det ? cmp_id : '0);

endmodule

// File: tb/tb_vdp_sprite_line_evaluator.sv
// Randomised bench for the sprite line evaluator against a per-line list model.
module tb_vdp_sprite_line_evaluator;

    localparam int N  = 16;
    localparam int D  = 4;
    localparam int RL = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic [8:0] render_y = '0;
    logic [3:0] sprite_test_id;
    logic [8:0] sprite_y;
    logic [5:0] sprite_height;
    logic       flip_y;
    logic       width_select_in;
    logic       hit_list_write_en;
    logic [2:0] hit_list_index;
    logic [3:0] hit_sprite_id;
    logic [5:0] hit_y_intersect;
    logic       hit_width_select;
    logic       hit_terminator;
    logic [2:0] hit_count;
    logic       busy;
    logic       finished;
    logic       overflow;
    logic [3:0] overflow_sprite_id;

    always #5 clk = ~clk;

    vdp_sprite_line_evaluator #(
        .SPRITES_TOTAL(N), .HIT_LIST_DEPTH(D), .Y_WIDTH(9), .HEIGHT_WIDTH(6), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .render_y(render_y),
        .sprite_test_id(sprite_test_id), .sprite_y(sprite_y), .sprite_height(sprite_height),
        .flip_y(flip_y), .width_select_in(width_select_in),
        .hit_list_write_en(hit_list_write_en), .hit_list_index(hit_list_index),
        .hit_sprite_id(hit_sprite_id), .hit_y_intersect(hit_y_intersect),
        .hit_width_select(hit_width_select), .hit_terminator(hit_terminator),
        .hit_count(hit_count), .busy(busy), .finished(finished),
        .overflow(overflow), .overflow_sprite_id(overflow_sprite_id)
    );

    // Attribute RAM with a two-cycle read.
    logic [8:0] sy_m [N];
    logic [5:0] sh_m [N];
    logic       fl_m [N];
    logic       ws_m [N];
    logic [3:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        a1 <= sprite_test_id;
        a2 <= a1;
    end
    assign sprite_y        = sy_m[a2];
    assign sprite_height   = sh_m[a2];
    assign flip_y          = fl_m[a2];
    assign width_select_in = ws_m[a2];

    int checks = 0;
    int errors = 0;
    int off = 0;
    bit chk_en = 1'b0;

    // Expected per-cycle trace, indexed by cycles after the start edge.
    int e_we [64], e_idx [64], e_id [64], e_int [64], e_ws [64], e_term [64];
    int e_cnt [64], e_busy [64], e_fin [64], e_ovf [64];
    int e_ovc, e_ovid, e_L;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at offset %0d: actual %0d required %0d", nm, off, act, exp);
        end
    endtask

    // Walk the sprites in id order, building the list the line must produce.
    task automatic model(input int ry);
        int cnt, ovc, fc, c, d, h, n;
        for (int i = 0; i < 64; i++) begin
            e_we[i] = 0; e_idx[i] = 0; e_id[i] = 0; e_int[i] = 0; e_ws[i] = 0; e_term[i] = 0;
        end
        cnt = 0; ovc = 0; e_ovid = 0;
        for (int k = 0; k < N; k++) begin
            h = int'(sh_m[k]);
            d = (ry - int'(sy_m[k])) & 511;
            if (h != 0 && d < h) begin
                c = k + RL + 2;
                if (cnt < D) begin
                    e_we[c] = 1; e_idx[c] = cnt; e_id[c] = k; e_ws[c] = int'(ws_m[k]);
                    e_int[c] = (fl_m[k] ? (h - 1 - d) : d) & 63;
                    cnt++;
                end else begin
                    ovc = c; e_ovid = k;
                    break;
                end
            end
        end
        if (ovc != 0) begin
            fc = ovc + 1;
        end else begin
            fc = N + RL + 3;
            if (cnt < D) begin
                e_we[N+RL+2] = 1; e_idx[N+RL+2] = cnt; e_term[N+RL+2] = 1;
            end
        end
        n = 0;
        for (int i = 1; i < 64; i++) begin
            e_cnt[i]  = n;
            if (e_we[i] != 0 && e_term[i] == 0) n++;
            e_busy[i] = (i < fc) ? 1 : 0;
            e_fin[i]  = (i >= fc) ? 1 : 0;
            e_ovf[i]  = (ovc != 0 && i >= ovc) ? 1 : 0;
        end
        e_ovc = ovc;
        e_L = fc + 2;
    endtask

    // Per-cycle comparison of the DUT against the model trace.
    always @(negedge clk) begin
        if (!chk_en) begin
            off = 0;
        end else begin
            off++;
            if (off < 64) begin
                chk("busy", int'(busy), e_busy[off]);
                chk("finished", int'(finished), e_fin[off]);
                chk("write_en", int'(hit_list_write_en), e_we[off]);
                chk("hit_count", int'(hit_count), e_cnt[off]);
                chk("overflow", int'(overflow), e_ovf[off]);
                if (e_ovf[off] != 0) chk("overflow_id", int'(overflow_sprite_id), e_ovid);
                if (e_we[off] != 0) begin
                    chk("index", int'(hit_list_index), e_idx[off]);
                    chk("terminator", int'(hit_terminator), e_term[off]);
                    chk("sprite_id", int'(hit_sprite_id), e_id[off]);
                    chk("intersect", int'(hit_y_intersect), e_int[off]);
                    chk("width_sel", int'(hit_width_select), e_ws[off]);
                end
                if (off <= N && (e_ovc == 0 || off <= e_ovc))
                    chk("test_id", int'(sprite_test_id), off - 1);
            end
        end
    end

    task automatic clear_mem();
        for (int k = 0; k < N; k++) begin
            sy_m[k] = '0; sh_m[k] = '0; fl_m[k] = 1'b0; ws_m[k] = 1'b0;
        end
    endtask

    // Called at a rising edge; pulses start for one cycle and arms the checker.
    task automatic start_scan(input int ry);
        #1;
        chk_en = 1'b0;
        render_y = 9'(ry);
        start = 1'b1;
        model(ry);
        @(negedge clk);
        chk("start_cycle_we", int'(hit_list_write_en), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic rand_cfg(input int ry, input int density);
        for (int k = 0; k < N; k++) begin
            sy_m[k] = 9'($urandom_range(0, 511));
            sh_m[k] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            if ($urandom_range(0, 9) < density) sy_m[k] = 9'((ry - int'($urandom_range(0, 24))) & 511);
            fl_m[k] = 1'($urandom_range(0, 1));
            ws_m[k] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        clear_mem();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_test_id", int'(sprite_test_id), 0);
        chk("rst_we", int'(hit_list_write_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_finished", int'(finished), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_count", int'(hit_count), 0);
        run(2);
        #1 reset_n = 1'b1;
        @(posedge clk);

        // Single hit: line 100, sprite 3 at Y=95 height 16.
        sy_m[3] = 9'd95; sh_m[3] = 6'd16;
        start_scan(100);
        chk("pin_a_we", e_we[7], 1);
        chk("pin_a_id", e_id[7], 3);
        chk("pin_a_int", e_int[7], 5);
        chk("pin_a_term", e_term[N+RL+2] * 10 + e_idx[N+RL+2], 11);
        run(e_L);
        chk("a_count", int'(hit_count), 1);
        chk("a_overflow", int'(overflow), 0);
        chk("a_finished", int'(finished), 1);

        // Same hit, vertically flipped.
        fl_m[3] = 1'b1;
        start_scan(100);
        chk("pin_flip_int", e_int[7], 10);
        run(e_L);

        // Wrap-around: sprite at Y=508 height 8.
        clear_mem();
        sy_m[0] = 9'd508; sh_m[0] = 6'd8;
        start_scan(2);
        chk("pin_wrap_int", e_int[4], 6);
        run(e_L);
        start_scan(4);
        chk("pin_wrap_miss", e_we[4], 0);
        chk("pin_wrap_term_idx", e_idx[N+RL+2], 0);
        run(e_L);

        // Overflow: ten hitting sprites into a four-entry list.
        clear_mem();
        for (int k = 0; k < 10; k++) begin
            sy_m[k] = 9'd40; sh_m[k] = 6'd8;
        end
        start_scan(43);
        chk("pin_ovf_cycle", e_ovc, 8);
        chk("pin_ovf_id", e_ovid, 4);
        chk("pin_ovf_noterm", e_we[N+RL+2], 0);
        run(e_L);
        chk("ovf_id_held", int'(overflow_sprite_id), 4);
        chk("ovf_count", int'(hit_count), 4);

        // Restart mid-scan while a write is due.
        clear_mem();
        for (int k = 0; k < 3; k++) begin
            sy_m[k] = 9'd200; sh_m[k] = 6'd4;
        end
        start_scan(201);
        run(4);
        start_scan(201);
        run(e_L);

        // Reset mid-scan.
        start_scan(201);
        run(5);
        chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_we", int'(hit_list_write_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(hit_count), 0);
        chk("arst_test_id", int'(sprite_test_id), 0);
        chk("arst_index", int'(hit_list_index), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", int'(hit_list_write_en) + int'(busy) + int'(finished), 0);
        end
        @(posedge clk);

        // Randomised lines of varying density.
        for (int i = 0; i < 12; i++) begin
            int ry;
            ry = int'($urandom_range(0, 511));
            rand_cfg(ry, (i % 3) * 3);
            start_scan(ry);
            run(e_L);
        end

        chk_en = 1'b0;
        run(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
